// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: clock, address/ALE/START/OE sequencer for an ADC0808-class SAR ADC with single or round-robin scan.
// Build macro ADC_AVG4_EN: convert each channel four times and report the truncated mean.
`timescale 1ns/1ps
module adc_scan_ctrl #(
  parameter int NUM_CH      = 8,
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8,
  parameter int CLK_DIV     = 13,
  parameter int ALE_CYC     = 4,
  parameter int EOC_TIMEOUT = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] ch_sel,
  input  logic              eoc_in,
  input  logic [DATA_W-1:0] adc_data,
  output logic              clk_adc,
  output logic              ale,
  output logic              start_conv,
  output logic              oe,
  output logic [ADDR_W-1:0] address_out,
  output logic              busy,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] ch_out,
  output logic              done_pulse,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LATCH, S_WAIT_LO, S_WAIT_HI, S_READ, S_NEXT, S_DONE
  } state_t;

  localparam int CNT_MAX = (EOC_TIMEOUT > ALE_CYC) ? EOC_TIMEOUT : ALE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = $clog2(CLK_DIV + 1);

  localparam logic [CNT_W-1:0]  ALE_LAST = CNT_W'(ALE_CYC - 1);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(EOC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  RD_LAST  = CNT_W'(1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_CH  = ADDR_W'(NUM_CH - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic              eoc_meta, eoc_s;
  logic              scan_mode;
  logic              accept, timeout_hit, read_last, conv_more;
  logic [DATA_W-1:0] sample;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      clk_adc <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      clk_adc <= ~clk_adc;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      eoc_meta <= 1'b0;
      eoc_s    <= 1'b0;
    end else begin
      eoc_meta <= eoc_in;
      eoc_s    <= eoc_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // One step counter, cleared on every state change, times ALE, each EOC wait and OE.
  always_ff @(posedge clk) begin
    if (!reset)                  cnt <= '0;
    else if (state_next != state) cnt <= '0;
    else if (state != S_IDLE)     cnt <= cnt + CNT_W'(1);
  end

  // NOTE: every signal assigned here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    busy        = (state != S_IDLE);
    ale         = 1'b0;
    start_conv  = 1'b0;
    oe          = 1'b0;
    done_pulse  = 1'b0;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    read_last   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_ADDR;
        end
      end
      S_ADDR: state_next = S_LATCH;
      S_LATCH: begin
        ale        = 1'b1;
        start_conv = 1'b1;
        if (cnt == ALE_LAST) state_next = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!eoc_s) begin
          state_next = S_WAIT_HI;
        end else if (cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_next  = S_DONE;
        end
      end
      S_WAIT_HI: begin
        if (eoc_s) begin
          state_next = S_READ;
        end else if (cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_next  = S_DONE;
        end
      end
      S_READ: begin
        oe = 1'b1;
        if (cnt == RD_LAST) begin
          read_last  = 1'b1;
          state_next = conv_more ? S_ADDR : S_NEXT;
        end
      end
      S_NEXT: state_next = (!scan_mode || address_out == LAST_CH) ? S_DONE : S_ADDR;
      S_DONE: begin
        done_pulse = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef ADC_AVG4_EN
  logic [1:0]        conv_idx;
  logic [DATA_W+1:0] acc, acc_sum;

  assign acc_sum   = acc + {2'b00, adc_data};
  assign conv_more = (conv_idx != 2'd3);
  assign sample    = acc_sum[DATA_W+1:2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      conv_idx <= '0;
      acc      <= '0;
    end else if (accept || timeout_hit) begin
      conv_idx <= '0;
      acc      <= '0;
    end else if (read_last) begin
      if (conv_more) begin
        conv_idx <= conv_idx + 2'd1;
        acc      <= acc_sum;
      end else begin
        conv_idx <= '0;
        acc      <= '0;
      end
    end
  end
`else
  assign conv_more = 1'b0;
  assign sample    = adc_data;
`endif

  // address_out doubles as the current-channel register; it changes only on entry to ADDR.
  always_ff @(posedge clk) begin
    if (!reset) begin
      address_out <= '0;
      scan_mode   <= 1'b0;
      timeout_err <= 1'b0;
      data_valid  <= 1'b0;
      data_out    <= '0;
      ch_out      <= '0;
    end else begin
      data_valid <= 1'b0;
      if (accept) begin
        scan_mode   <= mode;
        address_out <= mode ? '0 : ch_sel;
        timeout_err <= 1'b0;
      end
      if (timeout_hit) timeout_err <= 1'b1;
      if (state == S_NEXT && state_next == S_ADDR) address_out <= address_out + ADDR_W'(1);
      if (read_last && !conv_more) begin
        data_valid <= 1'b1;
        data_out   <= sample;
        ch_out     <= address_out;
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: randomized bench with an ADC pin model and a per-run expected-sample queue.
// Build with ADC_AVG4_EN defined to exercise the four-sample averaging variant.
`timescale 1ns/1ps
module tb_adc_scan_ctrl;

  localparam int NUM_CH      = 8;
  localparam int ADDR_W      = 3;
  localparam int DATA_W      = 8;
  localparam int CLK_DIV     = 13;
  localparam int ALE_CYC     = 4;
  localparam int EOC_TIMEOUT = 2048;
`ifdef ADC_AVG4_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] ch;
    logic [DATA_W-1:0] data;
  } samp_t;

  logic              clk = 1'b0;
  logic              reset, start, mode, eoc_in;
  logic [ADDR_W-1:0] ch_sel;
  logic [DATA_W-1:0] adc_data;
  logic              clk_adc, ale, start_conv, oe, busy, data_valid, done_pulse, timeout_err;
  logic [ADDR_W-1:0] address_out, ch_out;
  logic [DATA_W-1:0] data_out;

  int n_cmp = 0;
  int n_err = 0;

  adc_scan_ctrl #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .CLK_DIV(CLK_DIV), .ALE_CYC(ALE_CYC), .EOC_TIMEOUT(EOC_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .ch_sel(ch_sel),
    .eoc_in(eoc_in), .adc_data(adc_data), .clk_adc(clk_adc), .ale(ale),
    .start_conv(start_conv), .oe(oe), .address_out(address_out), .busy(busy),
    .data_valid(data_valid), .data_out(data_out), .ch_out(ch_out),
    .done_pulse(done_pulse), .timeout_err(timeout_err)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ADC pin model: eoc pulses high for 4 clk, eoc_dly clk after ale rises; data valid from the 2nd oe cycle.
  logic [DATA_W-1:0] data_tab [0:NUM_CH-1][0:3];
  bit                eoc_en  = 1'b1;
  int                eoc_dly = 50;
  int                run_id  = 0;
  int                model_run = -1;
  int                eoc_wait = 0;
  int                eoc_hold = 0;
  int                cur_k = 0;
  logic [ADDR_W-1:0] cur_addr = '0;
  logic              ale_d = 1'b0;
  logic              oe_d = 1'b0;
  logic              rst_seen = 1'b0;

  always @(posedge clk) begin
    ale_d    <= ale;
    oe_d     <= oe;
    rst_seen <= reset;
    if (eoc_wait > 0) begin
      if (eoc_wait == 1) eoc_hold <= 4;
      eoc_wait <= eoc_wait - 1;
    end else if (eoc_hold > 0) begin
      eoc_hold <= eoc_hold - 1;
    end
    if (ale && !ale_d) begin
      if (run_id != model_run || address_out != cur_addr || cur_k == NCONV - 1) cur_k <= 0;
      else cur_k <= cur_k + 1;
      model_run <= run_id;
      cur_addr  <= address_out;
      eoc_wait  <= eoc_dly;
    end
  end

  assign eoc_in   = eoc_en && (eoc_hold > 0);
  assign adc_data = (oe && oe_d) ? data_tab[cur_addr][cur_k] : 8'hA5;

  // Reference: each reported sample is the integer mean of that channel's NCONV conversions.
  function automatic logic [DATA_W-1:0] exp_sample(input int ch);
    int sum = 0;
    for (int k = 0; k < NCONV; k++) sum += int'(data_tab[ch][k]);
    return DATA_W'(sum / NCONV);
  endfunction

  samp_t             exp_q[$];
  samp_t             e;
  int                n_valid = 0;
  int                adc_cnt = 0;
  int                ale_len = 0;
  logic              adc_prev = 1'b0;
  logic              ale_q = 1'b0;
  logic [ADDR_W-1:0] addr_q = '0;

  always @(negedge clk) begin
    if (!rst_seen) begin
      adc_cnt  = 0;
      adc_prev = clk_adc;
    end else begin
      adc_cnt++;
      if (clk_adc != adc_prev) begin
        check("clk_adc_period", adc_cnt, CLK_DIV);
        adc_cnt  = 0;
        adc_prev = clk_adc;
      end
    end
    if (ale && !ale_q) begin
      check("addr_setup", address_out, addr_q);
      check("start_conv", start_conv, 1);
      ale_len = 0;
    end
    if (ale) ale_len++;
    if (!ale && ale_q) check("ale_len", ale_len, ALE_CYC);
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("ch_out", ch_out, e.ch);
        check("data_out", data_out, e.data);
      end
      n_valid++;
    end
    ale_q  = ale;
    addr_q = address_out;
  end

  task automatic run_op(input logic m, input logic [ADDR_W-1:0] ch, input bit extra, input bit expect_to);
    int base, since, n_exp;
    bit got_done;
    n_exp = 0;
    if (!expect_to) begin
      if (m) begin
        for (int c = 0; c < NUM_CH; c++) begin
          exp_q.push_back({ADDR_W'(c), exp_sample(c)});
          n_exp++;
        end
      end else begin
        exp_q.push_back({ch, exp_sample(int'(ch))});
        n_exp = 1;
      end
    end
    base = n_valid;
    since = 0;
    got_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mode = m; ch_sel = ch; run_id++;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; ch_sel = ch + ADDR_W'(1);
    check("busy_after_start", busy, 1);
    check("timeout_cleared", timeout_err, 0);
    for (int i = 0; i < 20000 && !got_done; i++) begin
      @(posedge clk); #1;
      start = extra && (i == 20);
      if (ale) since = 0;
      else since++;
      if (done_pulse) got_done = 1'b1;
    end
    check("done_seen", got_done, 1);
    // one WAIT_LO cycle, EOC_TIMEOUT WAIT_HI cycles, then the DONE cycle
    if (expect_to) check("timeout_latency", since, EOC_TIMEOUT + 2);
    check("timeout_err", timeout_err, expect_to);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done_pulse, 0);
    check("valid_count", n_valid - base, n_exp);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {clk_adc, ale, start_conv, oe, address_out, busy, data_valid,
                data_out, ch_out, done_pulse, timeout_err}, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0; ch_sel = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 4; k++) data_tab[c][k] = '0;
    repeat (5) @(posedge clk); #1;
    check_reset_outputs("reset_outputs");
    reset = 1'b1;
    repeat (40) @(posedge clk); #1;
    check("idle_busy", busy, 0);

    // single conversion on channel 3
    for (int k = 0; k < 4; k++) data_tab[3][k] = 8'h40;
    run_op(1'b0, 3'd3, 1'b0, 1'b0);

    // full scan; data = 0x10*ch (+conversion index, so the averaged build yields 0x10*ch+1)
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 4; k++) data_tab[c][k] = DATA_W'(8'h10 * c + k);
    run_op(1'b1, 3'd0, 1'b0, 1'b0);

    // start pulsed while busy must be dropped
    run_op(1'b0, 3'd5, 1'b1, 1'b0);

    // EOC stuck low -> timeout, then the next start clears the flag
    eoc_en = 1'b0;
    run_op(1'b0, 3'd2, 1'b0, 1'b1);
    eoc_en = 1'b1;
    run_op(1'b0, 3'd2, 1'b0, 1'b0);

    // reset while waiting for EOC
    eoc_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; ch_sel = 3'd4; run_id++;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (ALE_CYC + 20) @(posedge clk); #1;
    check("busy_before_reset", busy, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check_reset_outputs("reset_mid_outputs");
    eoc_en = 1'b1;
    run_op(1'b0, 3'd4, 1'b0, 1'b0);

    // randomized operations
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < 4; k++) data_tab[c][k] = DATA_W'($urandom);
      eoc_dly = $urandom_range(12, 80);
      run_op(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, NUM_CH - 1)),
             1'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
